dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the far end of the core's load/store port; the memory stage is the initiator.
- Accepts one request at a time over a valid/ready channel and performs it on an internal word array.
- Returns load data, sign- or zero-extended, or a store acknowledge after a fixed latency, over a valid/ready response channel.
- Flags misaligned and out-of-range accesses with an error response.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >=4)
BASE_ADDR, 32'h0001_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  response present
rsp_ready  in  1  initiator accepts the response
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  access faulted

Behaviour:
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE) & rst_n (combinational).
- Reset (async assert, sync release):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Array contents are not reset.
- Accept: req_valid & req_ready high at a rising edge.
  - All request fields are captured at that edge.
  - Error check at accept:
    - err = 1 if size==3, or if misaligned (half with addr[0]!=0; word with addr[1:0]!=0).
    - err = 1 if addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH_WORDS*4.
  - Stores without error commit at the accept edge, using byte lanes from addr[1:0] and size:
    - byte: replicate wdata[7:0] to all lanes; write lane addr[1:0] only.
    - half: replicate wdata[15:0]; write lanes {addr[1],0} and {addr[1],1}.
    - word: write all lanes.
  - Faulting stores write nothing.
  - Loads read the word at the accept edge.
    - Extract the lane(s) selected by addr[1:0] and size.
    - Extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
    - The result is held internally until it is presented.
- Latency:
  - An accept edge in cycle c gives rsp_valid=1 in cycle c+LATENCY.
  - LATENCY==1: go IDLE->RESP directly.
  - Otherwise go IDLE->WAIT; the counter loads LATENCY-1, decrements each edge, and the block moves to RESP when it reaches 1.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable.
  - rsp_rdata = 0 if store or err=1.
  - Hold until rsp_ready=1 at an edge, then go to IDLE.
  - rsp_valid=0 and rsp_rdata/rsp_err clear to 0 on that edge.
  - req_ready=1 in the following cycle. A request and its response never overlap, so throughput is at most one access per LATENCY+1 cycles.
- rsp_ready is ignored outside RESP. req_valid is ignored outside IDLE, and the initiator must hold the request stable until accepted.
- Read-after-write: a load accepted after a store's response sees the stored data.
- Reset mid-operation: the pending response is discarded and the FSM returns to IDLE. A store already committed at its accept edge remains in the array.
- Address index = (addr - BASE_ADDR) >> 2, width log2(DEPTH_WORDS). No wrap: out-of-range addresses always fault.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; no response appears without req_valid.
- Word store/load with LATENCY=2:
  - Store 32'hDEADBEEF at 32'h0001_0008, accepted in cycle c -> rsp_valid=1 in cycle c+2 with rdata=0, err=0; rsp_ready=1 -> req_ready=1 the next cycle.
  - Load from the same address -> rdata=32'hDEADBEEF.
- Sub-word extension:
  - Store byte 8'h80 to 32'h0001_000D.
  - lb 32'h0001_000D -> 32'hFFFF_FF80; lbu -> 32'h0000_0080.
  - lhu 32'h0001_000C -> 32'h0000_80EF (remaining bytes from the DEADBEEF word at 0x0C, which was written first).
- Errors:
  - Word load at 32'h0001_0002 -> err=1, rdata=0.
  - Store to 32'h0000_FFFC -> err=1, and a following load of BASE_ADDR-adjacent words shows no change.
  - req_size=3 -> err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stay constant, req_ready=0 and a new req_valid is not accepted; release -> exactly one handshake.
- Reset mid-WAIT: assert rst_n=0 one cycle after a store is accepted -> rsp_valid=0 immediately; after release, a load of that address returns the stored value.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-port data-memory responder with fixed-latency valid/ready response
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_LOAD    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_res;
    logic          r_res_err;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_misalign;
    logic          w_err;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_rword;
    logic [31:0]   w_load;
    logic [31:0]   w_res;

    assign req_ready  = (r_state == S_IDLE) & rst_n;
    assign w_accept   = req_valid & req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;

    // No wrap-around: the offset must be non-negative and below the array size.
    assign w_off      = req_addr - BASE_ADDR;
    assign w_in_range = (req_addr >= BASE_ADDR) && (w_off < DEPTH_BYTES);
    assign w_idx      = w_off[AW+1:2];
    assign w_rword    = r_mem[w_idx];
    assign w_err      = (req_size == 2'd3) | w_misalign | ~w_in_range;
    assign w_res      = (req_we | w_err) ? 32'd0 : w_load;

    // Alignment check: halves need addr[0]==0, words need addr[1:0]==0.
    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            2'd1:    w_misalign = req_addr[0];
            2'd2:    w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    // Store lane enables and replicated write data so any lane sees the right bytes.
    always_comb begin
        w_be    = 4'b1111;
        w_wword = req_wdata;
        case (req_size)
            2'd0: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wword = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wword = req_wdata;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension; words ignore req_unsigned.
    always_comb begin
        w_load = w_rword;
        case (req_size)
            2'd0: begin
                if (req_unsigned)
                    w_load = {24'd0, w_rword[{req_addr[1:0], 3'b000} +: 8]};
                else
                    w_load = {{24{w_rword[{req_addr[1:0], 3'b111}]}},
                              w_rword[{req_addr[1:0], 3'b000} +: 8]};
            end
            2'd1: begin
                if (req_unsigned)
                    w_load = {16'd0, w_rword[{req_addr[1], 4'b0000} +: 16]};
                else
                    w_load = {{16{w_rword[{req_addr[1], 4'b1111}]}},
                              w_rword[{req_addr[1], 4'b0000} +: 16]};
            end
            default: w_load = w_rword;
        endcase
    end

    // Stores commit at the accept edge; faulting stores are dropped. Array is never reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    // Request/response FSM: capture result at accept, count latency, hold until rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_res       <= 32'd0;
            r_res_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_res     <= w_res;
                        r_res_err <= w_err;
                        if (LATENCY == 1) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_res;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state     <= S_RESP;
                        r_cnt       <= 4'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_res;
                        r_rsp_err   <= r_res_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - vector table, corner sequences and random model check for dmem_responder
module tb_dmem_responder;

    localparam int unsigned DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          LAT    = 2;
    localparam longint      BASE_L = 64'h0001_0000;
    localparam longint      SPAN_L = 64'd4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mb [64];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic add_vec(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd, input logic err,
                           input logic [31:0] rd);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns;
        v.wdata = wd; v.err = err; v.rdata = rd;
        vecs.push_back(v);
    endtask

    // One full transaction; lat = cycles from accept edge to first rsp_valid sample, -1 on timeout.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat);
        int n;
        err = 1'b0; rd = 32'd0; lat = -1;
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid && n < 20);
            if (rsp_valid) begin
                lat = n;
                rd = rsp_rdata;
                err = rsp_err;
                rsp_ready = 1'b1;
                @(posedge clk);
                #1 rsp_ready = 1'b0;
            end
        end
    endtask

    // Byte-addressed reference of the low 64 bytes of the array.
    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd);
        longint a, off, v;
        int n;
        a = {32'd0, addr};
        n = 1 << size;
        err = (size == 2'd3) || (a % n != 0) || (a < BASE_L) || (a >= BASE_L + SPAN_L);
        rd = 32'd0;
        if (!err) begin
            off = a - BASE_L;
            if (we) begin
                for (int k = 0; k < n; k++) mb[int'(off) + k] = 8'(wd >> (8 * k));
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v | ({56'd0, mb[int'(off) + k]} << (8 * k));
                if (!uns && n < 4 && v >= (64'sd1 <<< (8 * n - 1)))
                    v = v - (64'sd1 <<< (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    initial begin
        logic        e, me;
        logic [31:0] r, mr, addr;
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] wd;
        int          lat, n, cnt, kind, off;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("ready during reset", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("idle no spurious rsp", 32'(cnt), 32'd0);

        // Directed vector table: we, addr, size, uns, wdata, exp_err, exp_rdata
        add_vec(1, 32'h0001_0008, 2, 0, 32'hDEADBEEF, 0, 32'h0);
        add_vec(0, 32'h0001_0008, 2, 0, 32'h0,        0, 32'hDEADBEEF);
        add_vec(1, 32'h0001_000C, 2, 0, 32'hDEADBEEF, 0, 32'h0);
        add_vec(1, 32'h0001_000D, 0, 0, 32'hAABBCC80, 0, 32'h0);
        add_vec(0, 32'h0001_000D, 0, 0, 32'h0,        0, 32'hFFFFFF80);
        add_vec(0, 32'h0001_000D, 0, 1, 32'h0,        0, 32'h00000080);
        add_vec(0, 32'h0001_000C, 1, 1, 32'h0,        0, 32'h000080EF);
        add_vec(0, 32'h0001_000E, 1, 0, 32'h0,        0, 32'hFFFFDEAD);
        add_vec(0, 32'h0001_000C, 2, 1, 32'h0,        0, 32'hDEAD80EF);
        add_vec(0, 32'h0001_0002, 2, 0, 32'h0,        1, 32'h0);
        add_vec(1, 32'h0001_0000, 2, 0, 32'hCAFEF00D, 0, 32'h0);
        add_vec(1, 32'h0000_FFFC, 2, 0, 32'h11111111, 1, 32'h0);
        add_vec(0, 32'h0001_0000, 2, 0, 32'h0,        0, 32'hCAFEF00D);
        add_vec(0, 32'h0001_0010, 3, 0, 32'h0,        1, 32'h0);
        add_vec(1, 32'h0001_0010, 3, 0, 32'h22222222, 1, 32'h0);
        add_vec(0, 32'h0001_0001, 1, 0, 32'h0,        1, 32'h0);
        add_vec(1, 32'h0001_0FFC, 2, 0, 32'h5A5AA5A5, 0, 32'h0);
        add_vec(0, 32'h0001_0FFC, 2, 0, 32'h0,        0, 32'h5A5AA5A5);
        add_vec(0, 32'h0001_1000, 2, 0, 32'h0,        1, 32'h0);
        add_vec(1, 32'h0001_000A, 1, 0, 32'hFFFF1234, 0, 32'h0);
        add_vec(1, 32'h0001_0009, 2, 0, 32'h00000000, 1, 32'h0);
        add_vec(0, 32'h0001_0008, 2, 0, 32'h0,        0, 32'h1234BEEF);
        add_vec(0, 32'h0001_000B, 0, 0, 32'h0,        0, 32'h00000012);

        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, e, r, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].err));
            chk($sformatf("vec%0d rdata", i), r, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("vec%0d ready after hs", i), 32'(req_ready), 32'd1);
            chk($sformatf("vec%0d valid after hs", i), 32'(rsp_valid), 32'd0);
        end

        // Backpressure: response held 5 cycles while a store is offered and must be ignored
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h0001_0008; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk("bp latency", 32'(n), 32'(LAT));
        req_we = 1'b1; req_wdata = 32'h0; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d rsp_rdata", k), rsp_rdata, 32'h1234BEEF);
            chk($sformatf("bp%0d rsp_err", k), 32'(rsp_err), 32'd0);
            chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("bp single handshake", 32'(cnt), 32'd0);
        txn(1'b0, 32'h0001_0008, 2'd2, 1'b0, 32'h0, e, r, lat);
        chk("bp store ignored", r, 32'h1234BEEF);

        // Reset one cycle after a store is accepted
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h0001_0020; req_size = 2'd2; req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midwait rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midwait req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("midwait response discarded", 32'(cnt), 32'd0);
        chk("midwait ready after release", 32'(req_ready), 32'd1);
        txn(1'b0, 32'h0001_0020, 2'd2, 1'b0, 32'h0, e, r, lat);
        chk("midwait store kept", r, 32'h0BADF00D);

        // Reset while a response is being presented
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h0001_0020; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk("midresp data", rsp_rdata, 32'h0BADF00D);
        rst_n = 1'b0;
        #1;
        chk("midresp rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midresp rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random phase: seed the low 16 words, then mixed accesses vs. the byte model
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            addr = BASE + 32'(4 * w);
            model(1'b1, addr, 2'd2, 1'b0, wd, me, mr);
            txn(1'b1, addr, 2'd2, 1'b0, wd, e, r, lat);
            chk($sformatf("init%0d err", w), 32'(e), 32'(me));
        end
        for (int t = 0; t < 200; t++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wd   = $urandom;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                addr = BASE - 32'($urandom_range(1, 16));
            end else if (kind == 1) begin
                addr = BASE + 32'd4096 + 32'($urandom_range(0, 63));
            end else if (kind == 2) begin
                addr = 32'h8000_0000 | $urandom;
            end else begin
                off = int'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0 && size != 2'd3)
                    off = off & ~((1 << size) - 1);
                addr = BASE + 32'(off);
            end
            model(we, addr, size, uns, wd, me, mr);
            txn(we, addr, size, uns, wd, e, r, lat);
            chk($sformatf("rnd%0d latency a=%h", t, addr), 32'(lat), 32'(LAT));
            chk($sformatf("rnd%0d err a=%h sz=%0d", t, addr, size), 32'(e), 32'(me));
            chk($sformatf("rnd%0d rdata a=%h sz=%0d u=%0d", t, addr, size, uns), r, mr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
